// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end of the sync RAM.
package spi_pkg;

  localparam int unsigned RX_W_DEF = 10;
  localparam int unsigned TX_W_DEF = 8;

  // Opcodes carried in bits [9:8] of the command word; decoded by the RAM.
  localparam logic [1:0] OPC_WR_ADDR = 2'b00;
  localparam logic [1:0] OPC_WR_DATA = 2'b01;
  localparam logic [1:0] OPC_RD_ADDR = 2'b10;
  localparam logic [1:0] OPC_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA_RX,
    READ_DATA_WAIT,
    READ_DATA_TX,
    DONE
  } state_e;

  // States in which MOSI bits are shifted into the command word.
  function automatic logic is_rx_state(input state_e s);
    return (s == WRITE) || (s == READ_ADD) || (s == READ_DATA_RX);
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Shift register with bit counter: serial-in/parallel-out for receive,
// parallel-load/serial-out (MSB first) for transmit.
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int unsigned W = TX_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] pdin,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] pout_next,
  output logic         sout,
  output logic         last
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  q;
  logic [CW-1:0] cnt;

  // Word as it will look after the current shift; lets the owner capture
  // the complete word on the same edge that samples its final bit.
  assign pout_next = {q[W-2:0], sin};
  assign sout      = q[W-1];
  assign last      = (cnt == CW'(W - 1));

  // Data and counter update; clear wins over load, load wins over shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      cnt <= '0;
    end else if (clr) begin
      q   <= '0;
      cnt <= '0;
    end else if (load) begin
      q   <= pdin;
      cnt <= '0;
    end else if (shift) begin
      q   <= pout_next;
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises MOSI command words for the RAM and
// returns RAM read data on MISO, MSB first.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int unsigned RX_W = RX_W_DEF,
  parameter int unsigned TX_W = TX_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            SS_n,
  input  logic            MOSI,
  output logic            MISO,
  output logic [RX_W-1:0] rx_data,
  output logic            rx_valid,
  input  logic [TX_W-1:0] tx_data,
  input  logic            tx_valid
);

  state_e state;
  logic   rd_addr_seen;

  logic            rx_clr, rx_shift, rx_last, rx_sout_unused;
  logic [RX_W-1:0] rx_word;
  logic            tx_clr, tx_load, tx_shift, tx_last, tx_sout;
  logic [TX_W-1:0] tx_pout_unused;

  assign rx_clr   = SS_n || (state == IDLE);
  assign rx_shift = !SS_n && is_rx_state(state);
  assign tx_clr   = SS_n;
  assign tx_load  = !SS_n && (state == READ_DATA_WAIT) && tx_valid;
  assign tx_shift = !SS_n && (state == READ_DATA_TX);

  spi_shift_reg #(.W(RX_W)) u_rx_shift (
    .clk       (clk),
    .rst       (rst),
    .clr       (rx_clr),
    .load      (1'b0),
    .pdin      ('0),
    .shift     (rx_shift),
    .sin       (MOSI),
    .pout_next (rx_word),
    .sout      (rx_sout_unused),
    .last      (rx_last)
  );

  // Zeros shift in behind the read data, so the register (and MISO) is
  // already zero once all TX_W bits are out.
  spi_shift_reg #(.W(TX_W)) u_tx_shift (
    .clk       (clk),
    .rst       (rst),
    .clr       (tx_clr),
    .load      (tx_load),
    .pdin      (tx_data),
    .shift     (tx_shift),
    .sin       (1'b0),
    .pout_next (tx_pout_unused),
    .sout      (tx_sout),
    .last      (tx_last)
  );

  // MISO comes straight from the TX register MSB, which is a flop.
  assign MISO = tx_sout;

  // Frame sequencing, command word hand-off and read-address tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= CHK_CMD;
          CHK_CMD: begin
            if (!MOSI)             state <= WRITE;
            else if (rd_addr_seen) state <= READ_DATA_RX;
            else                   state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA_RX: begin
            if (rx_last) begin
              rx_data  <= rx_word;
              rx_valid <= 1'b1;
              if (state == READ_DATA_RX) begin
                rd_addr_seen <= 1'b0;
                state        <= READ_DATA_WAIT;
              end else begin
                if (state == READ_ADD) rd_addr_seen <= 1'b1;
                state <= DONE;
              end
            end
          end
          READ_DATA_WAIT: if (tx_valid) state <= READ_DATA_TX;
          READ_DATA_TX:   if (tx_last)  state <= DONE;
          DONE:           state <= DONE;
          default:        state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- Serial front end that sits directly upstream of the single-port/dual-port sync RAM.
- Deserialises MOSI frames into the RAM's 10-bit command word (din / rx_valid) and returns read data serially on MISO.
- Read data is taken from the RAM's dout / tx_valid and shifted out MSB first.
- Master-driven chip select (SS_n, active-low). MOSI is sampled on clk rising edge.

Parameters:
- RX_W, 10, command word width: bits [9:8] opcode, [7:0] address/data.
- TX_W, 8, read-data width returned on MISO.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- SS_n  input  1  chip select, active-low; high aborts/ends the frame.
- MOSI  input  1  serial data from master, MSB first.
- MISO  output  1  serial read data to master, MSB first.
- rx_data  output  RX_W  command word to RAM (RAM din).
- rx_valid  output  1  one-cycle strobe; rx_data is valid in that cycle.
- tx_data  input  TX_W  read data from RAM (RAM dout).
- tx_valid  input  1  read-data strobe from RAM.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, rx_data=0, rx_valid=0, MISO=0, bit counter=0, rd_addr_seen=0, tx shift register=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA_RX, READ_DATA_WAIT, READ_DATA_TX, DONE.
- IDLE: if SS_n=0 at a posedge, go to CHK_CMD. Otherwise stay.
- CHK_CMD: sample MOSI as the type bit.
  - Type bit 0 -> WRITE.
  - Type bit 1 and rd_addr_seen=0 -> READ_ADD.
  - Type bit 1 and rd_addr_seen=1 -> READ_DATA_RX.
- WRITE / READ_ADD / READ_DATA_RX:
  - Shift exactly RX_W MOSI bits, MSB first, into the shift register; counter counts 0..RX_W-1.
  - On the cycle the RX_W-th bit is sampled, the next edge loads rx_data with the full word and pulses rx_valid=1 for exactly one cycle.
  - Latency: rx_valid is asserted 1 cycle after the last MOSI bit is sampled.
  - WRITE and READ_ADD then go to DONE. READ_ADD also sets rd_addr_seen=1.
  - READ_DATA_RX goes to READ_DATA_WAIT and clears rd_addr_seen=0.
- Opcode bits: the block does not check rx_data[9:8] against the type bit; the word is passed to the RAM unmodified.
- READ_DATA_WAIT: wait for tx_valid=1, then latch tx_data into the TX shift register and go to READ_DATA_TX.
- READ_DATA_TX:
  - MISO drives shift[TX_W-1] for TX_W consecutive cycles, shifting left each cycle.
  - The first MISO bit appears 1 cycle after tx_valid is sampled.
  - After TX_W bits go to DONE with MISO=0.
- DONE: ignore MOSI, MISO=0, rx_valid=0. Stay until SS_n=1, then go to IDLE.
- SS_n=1 in any state other than IDLE:
  - Next state is IDLE; counter cleared; MISO=0.
  - A partial word is discarded and no rx_valid is issued.
  - rd_addr_seen is unchanged, except when the abort happens in READ_DATA_WAIT or READ_DATA_TX; there it is already cleared.
- tx_valid outside READ_DATA_WAIT is ignored.
- rx_valid is never asserted more than once per frame.
- Async reset mid-frame returns to the reset values immediately; any in-flight frame is lost.
- Frame lengths in clk cycles after SS_n falls: write = 1+1+RX_W; read-address = same; read-data = 1+1+RX_W+wait+TX_W.

Decomposition:
- Package spi_pkg:
  - state_e enum for the FSM states.
  - Constants: OPC_WR_ADDR=2'b00, OPC_WR_DATA=2'b01, OPC_RD_ADDR=2'b10, OPC_RD_DATA=2'b11, plus the default widths.
- One sub-module, spi_shift_reg: parameterised width; serial-in/parallel-out and parallel-load/serial-out, with a counter-done flag. It is instantiated for RX and TX.
- FSM and rd_addr_seen stay in the top level.

Test Plan:
- Write-address frame: SS_n low, MOSI type=0 then 10'b00_1010_0101 -> rx_valid pulses once with rx_data=10'h0A5, 1 cycle after the last bit. MISO stays 0.
- Write-data frame: type=0, 10'b01_0011_1100 -> rx_valid once, rx_data=10'h13C. Combined with the preceding write-address frame, the RAM holds 8'h3C at 8'hA5.
- Read-address frame: type=1, 10'b10_1010_0101 -> rx_data=10'h2A5 and rd_addr_seen=1.
- Read-data frame: type=1, 10'b11_0000_0000 -> rx_data=10'h300 and rd_addr_seen=0. After the RAM's tx_valid with tx_data=8'h3C, MISO emits 0,0,1,1,1,1,0,0 on 8 consecutive cycles starting 1 cycle after tx_valid.
- Abort mid-word: SS_n rises after 5 data bits -> no rx_valid, state IDLE next cycle. A following full write frame 10'h0FF produces rx_data=10'h0FF.
- Reset mid-read: assert rst during READ_DATA_TX bit 3 -> MISO=0, rx_data=0, rd_addr_seen=0 immediately. A new read frame then takes the READ_ADD path.
